sbox_lookup_scheduler: RTL

- Time-multiplexes one shared S-box lookup port across the eight DES S-box substitutions of a round.
- Accepts one 48-bit key-mixed expansion word, issues eight 6-bit lookups S1..S8, one per cycle, and collects the eight 4-bit results into the 32-bit pre-permutation word.
- Sits between the round's E-expansion/key-XOR stage and the P-permutation stage.
- Drives the select/address of an external S1..S8 bank mux and reads its 4-bit result.

---
 rtl/des_pkg.sv | 27 ++
 rtl/sbox_bank.sv | 57 +++++
 rtl/sbox_lookup_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared constants, FSM state type and bit-position helpers for the DES
// S-box lookup path.
package des_pkg;

  localparam int NUM_SBOX = 8;
  localparam int CHUNK_W  = 6;
  localparam int NIB_W    = 4;
  localparam int IN_W     = NUM_SBOX * CHUNK_W;
  localparam int OUT_W    = NUM_SBOX * NIB_W;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DONE   = 2'd2
  } state_e;

  // S1 sits in the most significant chunk/nibble, S8 in the least.
  function automatic int chunkHi(input logic [IDX_W-1:0] k);
    return IN_W - 1 - CHUNK_W * int'(k);
  endfunction

  function automatic int nibHi(input logic [IDX_W-1:0] k);
    return OUT_W - 1 - NIB_W * int'(k);
  endfunction

endpackage

// File: rtl/sbox_bank.sv
// Shared bank holding the eight DES S-boxes, selected by Sel.
// With SBOX_REG_EN defined the result is registered (one cycle latency).
module sbox_bank
  import des_pkg::*;
(
`ifdef SBOX_REG_EN
  input  logic               Clk,
  input  logic               Rst_n,
`endif
  input  logic [IDX_W-1:0]   Sel,
  input  logic [CHUNK_W-1:0] Addr,
  output logic [NIB_W-1:0]   Data
);

  // Each S-box is four 64-bit rows, column 0 in the top nibble of its row.
  function automatic logic [255:0] sboxTable(input logic [IDX_W-1:0] s);
    case (s)
      3'd0:    sboxTable = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
      3'd1:    sboxTable = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
      3'd2:    sboxTable = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
      3'd3:    sboxTable = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
      3'd4:    sboxTable = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
      3'd5:    sboxTable = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
      3'd6:    sboxTable = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
      default: sboxTable = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
    endcase
  endfunction

  logic [255:0]     tbl;
  logic [1:0]       row;
  logic [3:0]       col;
  int               bitHi;
  logic [NIB_W-1:0] nib;

  // Row comes from the outer address bits, column from the inner four.
  always_comb begin
    tbl   = sboxTable(Sel);
    row   = {Addr[CHUNK_W-1], Addr[0]};
    col   = Addr[CHUNK_W-2:1];
    bitHi = 255 - 64 * int'(row) - 4 * int'(col);
    nib   = tbl[bitHi -: NIB_W];
  end

`ifdef SBOX_REG_EN
  logic [NIB_W-1:0] data_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) data_q <= '0;
    else        data_q <= nib;
  end

  assign Data = data_q;
`else
  assign Data = nib;
`endif

endmodule

// File: rtl/sbox_lookup_scheduler.sv
// Time-multiplexes one shared S-box port over S1..S8 for a 48-bit word.
// Define SBOX_REG_EN when the bank output is registered (pipelined capture).
module sbox_lookup_scheduler
  import des_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [IN_W-1:0]    DataIn,
  output logic [IDX_W-1:0]   SboxSel,
  output logic [CHUNK_W-1:0] SboxAddr,
  input  logic [NIB_W-1:0]   SboxData,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [OUT_W-1:0]   DataOut,
  output logic               Busy
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(NUM_SBOX);
`ifdef SBOX_REG_EN
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_SBOX);
`else
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_SBOX - 1);
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IN_W-1:0]    dataLatch_q, dataLatch_d;
  logic [OUT_W-1:0]   dataOut_q, dataOut_d;
  logic [IDX_W-1:0]   selHold_q, selHold_d;
  logic [CHUNK_W-1:0] addrHold_q, addrHold_d;

  logic               issue;
  logic               capture;
  logic [IDX_W-1:0]   issueIdx;
  logic [IDX_W-1:0]   capIdx;
  logic [CHUNK_W-1:0] chunk;

  // With a registered bank, the result arriving in cycle k belongs to k-1.
  always_comb begin
    issueIdx = count_q[IDX_W-1:0];
    issue    = (state_q == LOOKUP) && (count_q < ISSUE_END);
    chunk    = dataLatch_q[chunkHi(issueIdx) -: CHUNK_W];
`ifdef SBOX_REG_EN
    capture  = (state_q == LOOKUP) && (count_q != '0) && (count_q <= LAST_K);
    capIdx   = IDX_W'(count_q - CNT_W'(1));
`else
    capture  = issue;
    capIdx   = issueIdx;
`endif
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dataLatch_d = dataLatch_q;
    dataOut_d   = dataOut_q;
    selHold_d   = selHold_q;
    addrHold_d  = addrHold_q;
    InReady     = 1'b0;
    OutValid    = 1'b0;

    if (issue) begin
      selHold_d  = issueIdx;
      addrHold_d = chunk;
    end
    if (capture) begin
      dataOut_d[nibHi(capIdx) -: NIB_W] = SboxData;
    end

    case (state_q)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) begin
          dataLatch_d = DataIn;
          count_d     = '0;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (count_q > LAST_K) begin
          count_d = '0;
          state_d = IDLE;
        end else if (count_q == LAST_K) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        OutValid = 1'b1;
        if (OutReady) state_d = IDLE;
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dataLatch_q <= '0;
      dataOut_q   <= '0;
      selHold_q   <= '0;
      addrHold_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dataLatch_q <= dataLatch_d;
      dataOut_q   <= dataOut_d;
      selHold_q   <= selHold_d;
      addrHold_q  <= addrHold_d;
    end
  end

  // The bank sees live addresses only while issuing; otherwise the last one.
  assign SboxSel  = issue ? issueIdx : selHold_q;
  assign SboxAddr = issue ? chunk : addrHold_q;
  assign DataOut  = dataOut_q;
  assign Busy     = (state_q != IDLE);

endmodule
